powlib_fifoarb: RTL and testbench

- N-input round-robin arbiter that shares one powlib_sfifo write port among N valid/ready requesters.
- Each requester sends packets: beats with a last flag.
- Once granted, a requester keeps the grant until its last beat completes, so packets never interleave in the FIFO.
- Sits directly in front of the FIFO write interface: rddata/rdvld/rdrdy connect to FIFO wrdata/wrvld/wrrdy.

---
 rtl/powlib_fifoarb_if.sv | 28 ++
 rtl/powlib_fifoarb.sv | 88 ++++++++
 tb/tb_powlib_fifoarb.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/powlib_fifoarb_if.sv
// Requester-side and FIFO-side handshake bundle for powlib_fifoarb.
// slave = arbiter view, master = requesters/FIFO (bench) view.
interface powlib_fifoarb_if #(
  parameter int unsigned W = 16,
  parameter int unsigned N = 4
);
  localparam int unsigned WIDX = (N > 1) ? $clog2(N) : 1;

  logic [N*W-1:0]  wrdata;
  logic [N-1:0]    wrvld;
  logic [N-1:0]    wrlast;
  logic [N-1:0]    wrrdy;
  logic [W-1:0]    rddata;
  logic            rdvld;
  logic            rdlast;
  logic [WIDX-1:0] rdidx;
  logic            rdrdy;

  modport slave (
    input  wrdata, wrvld, wrlast, rdrdy,
    output wrrdy, rddata, rdvld, rdlast, rdidx
  );

  modport master (
    output wrdata, wrvld, wrlast, rdrdy,
    input  wrrdy, rddata, rdvld, rdlast, rdidx
  );
endinterface

// File: rtl/powlib_fifoarb.sv
// Round-robin, packet-locking arbiter sharing one FIFO write port among N requesters.
// Datapath is combinational from state; only state/prio/gnt are registered.
module powlib_fifoarb #(
  parameter int unsigned W    = 16,
  parameter int unsigned N    = 4,
  parameter int unsigned EPKT = 1
) (
  input logic               clk,
  input logic               rst,
  powlib_fifoarb_if.slave   bus
);
  localparam int unsigned WIDX = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state_q;
  logic [WIDX-1:0] prio_q;
  logic [WIDX-1:0] gnt_q;

  logic [WIDX-1:0] sel_c;
  logic            found_c;
  logic [31:0]     idx_c;
  logic            rdvld_c;
  logic            rdlast_c;
  logic            xfer_c;
  logic [N-1:0]    wrrdy_c;

  function automatic logic [WIDX-1:0] next_prio(input logic [WIDX-1:0] v);
    if (32'(v) + 32'd1 >= N) next_prio = '0;
    else                     next_prio = v + WIDX'(1);
  endfunction

  // Locked grant wins; otherwise first valid requester scanning from prio.
  always_comb begin
    sel_c   = prio_q;
    found_c = 1'b0;
    idx_c   = '0;
    if (state_q == LOCK) begin
      sel_c = gnt_q;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        idx_c = (32'(prio_q) + k) % N;
        if (!found_c && bus.wrvld[WIDX'(idx_c)]) begin
          sel_c   = WIDX'(idx_c);
          found_c = 1'b1;
        end
      end
    end
  end

  always_comb begin
    wrrdy_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      wrrdy_c[i] = bus.rdrdy && (WIDX'(i) == sel_c);
    end
  end

  assign rdvld_c    = bus.wrvld[sel_c];
  assign rdlast_c   = (EPKT != 0) ? bus.wrlast[sel_c] : 1'b1;
  assign xfer_c     = rdvld_c && bus.rdrdy;

  assign bus.rdidx  = sel_c;
  assign bus.rddata = bus.wrdata[32'(sel_c)*W +: W];
  assign bus.rdvld  = rdvld_c;
  assign bus.rdlast = rdlast_c;
  assign bus.wrrdy  = wrrdy_c;

  // Lock on a non-last beat, release and rotate priority on the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= '0;
      gnt_q   <= '0;
    end else if (xfer_c) begin
      if (state_q == IDLE) begin
        if (!rdlast_c) begin
          state_q <= LOCK;
          gnt_q   <= sel_c;
        end else begin
          prio_q  <= next_prio(sel_c);
        end
      end else if (rdlast_c) begin
        state_q <= IDLE;
        prio_q  <= next_prio(gnt_q);
      end
    end
  end
endmodule

// File: tb/tb_powlib_fifoarb.sv
// Directed bench for powlib_fifoarb: rotation, packet lock, bubbles, stalls, reset, EPKT=0.
module tb_powlib_fifoarb;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  powlib_fifoarb_if #(.W(16), .N(4)) bus ();
  powlib_fifoarb_if #(.W(16), .N(4)) bus2 ();

  powlib_fifoarb #(.W(16), .N(4), .EPKT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  powlib_fifoarb #(.W(16), .N(4), .EPKT(0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input logic [15:0] b);
    pk = {16'h3000 | b, 16'h2000 | b, 16'h1000 | b, 16'h0000 | b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.wrdata = '0;  bus.wrvld = '0;  bus.wrlast = '0;  bus.rdrdy = 1'b0;
    bus2.wrdata = '0; bus2.wrvld = '0; bus2.wrlast = '0; bus2.rdrdy = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;

    // Reset, idle
    #1;
    chk("rst_rdvld", 64'(bus.rdvld), 64'd0);
    chk("rst_wrrdy", 64'(bus.wrrdy), 64'h0);
    chk("rst_rdidx", 64'(bus.rdidx), 64'd0);
    bus.rdrdy = 1'b1;
    #1;
    chk("rst_wrrdy_rdy", 64'(bus.wrrdy), 64'h1);
    cyc();

    // All valid, single-beat packets: 0,1,2,3,0,1
    bus.wrvld = 4'hF; bus.wrlast = 4'hF; bus.wrdata = pk(16'h0);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rot_idx",  64'(bus.rdidx),  64'(k % 4));
      chk("rot_rdy",  64'(bus.wrrdy),  64'(1 << (k % 4)));
      chk("rot_data", 64'(bus.rddata), 64'((k % 4) << 12));
      chk("rot_vld",  64'(bus.rdvld),  64'd1);
      cyc();
    end

    // prio=2: requester 2 sends a 3-beat packet while all others valid
    bus.wrlast = 4'b1011; bus.wrdata = pk(16'h1);
    #1;
    chk("pkt_b1_idx",  64'(bus.rdidx),  64'd2);
    chk("pkt_b1_last", 64'(bus.rdlast), 64'd0);
    chk("pkt_b1_data", 64'(bus.rddata), 64'h2001);
    cyc();
    bus.wrdata = pk(16'h2);
    #1;
    chk("pkt_b2_idx",  64'(bus.rdidx),  64'd2);
    chk("pkt_b2_rdy",  64'(bus.wrrdy),  64'h4);
    cyc();
    bus.wrlast = 4'hF; bus.wrdata = pk(16'h3);
    #1;
    chk("pkt_b3_idx",  64'(bus.rdidx),  64'd2);
    chk("pkt_b3_last", 64'(bus.rdlast), 64'd1);
    chk("pkt_b3_data", 64'(bus.rddata), 64'h2003);
    cyc();
    #1;
    chk("pkt_next3", 64'(bus.rdidx), 64'd3);
    cyc();
    #1;
    chk("pkt_next0", 64'(bus.rdidx), 64'd0);
    cyc();

    // prio=1: lock on requester 1, then a 2-cycle bubble
    bus.wrlast = 4'b1101; bus.wrdata = pk(16'h1);
    #1;
    chk("lk_idx",  64'(bus.rdidx),  64'd1);
    chk("lk_last", 64'(bus.rdlast), 64'd0);
    cyc();
    bus.wrvld = 4'b1101;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("bub_vld", 64'(bus.rdvld), 64'd0);
      chk("bub_idx", 64'(bus.rdidx), 64'd1);
      chk("bub_rdy", 64'(bus.wrrdy), 64'h2);
      cyc();
    end
    bus.wrvld = 4'hF; bus.wrdata = pk(16'h2);
    #1;
    chk("res_vld",  64'(bus.rdvld),  64'd1);
    chk("res_idx",  64'(bus.rdidx),  64'd1);
    chk("res_data", 64'(bus.rddata), 64'h1002);
    cyc();

    // FIFO full for 5 cycles mid-packet
    bus.rdrdy = 1'b0; bus.wrdata = pk(16'h3);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("full_idx",  64'(bus.rdidx),  64'd1);
      chk("full_data", 64'(bus.rddata), 64'h1003);
      chk("full_rdy",  64'(bus.wrrdy),  64'h0);
      chk("full_vld",  64'(bus.rdvld),  64'd1);
      cyc();
    end
    bus.rdrdy = 1'b1; bus.wrlast = 4'hF;
    #1;
    chk("full_rel_last", 64'(bus.rdlast), 64'd1);
    chk("full_rel_rdy",  64'(bus.wrrdy),  64'h2);
    cyc();
    bus.rdrdy = 1'b0;
    #1;
    chk("after_pkt_idx", 64'(bus.rdidx), 64'd2);

    // Lock on requester 3 with requester 0 valid, then reset
    bus.wrvld = 4'b1001; bus.wrlast = 4'b0111; bus.rdrdy = 1'b1;
    #1;
    chk("l3_idx", 64'(bus.rdidx), 64'd3);
    cyc();
    #1;
    chk("l3_hold", 64'(bus.rdidx), 64'd3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_lk_idx", 64'(bus.rdidx), 64'd0);
    chk("rst_lk_rdy", 64'(bus.wrrdy), 64'h1);
    chk("rst_lk_vld", 64'(bus.rdvld), 64'd1);
    bus.wrvld = '0; bus.rdrdy = 1'b0;

    // EPKT=0: wrlast ignored, rotation as for single-beat packets
    bus2.wrvld = 4'hF; bus2.wrlast = 4'h0; bus2.wrdata = pk(16'h5); bus2.rdrdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("e0_idx",  64'(bus2.rdidx),  64'(k % 4));
      chk("e0_last", 64'(bus2.rdlast), 64'd1);
      chk("e0_data", 64'(bus2.rddata), 64'(((k % 4) << 12) | 5));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
